cond_branch_unit: RTL and testbench
===================================

Name: cond_branch_unit

Overview:
Consumer side of the condition-flag path in the 5-stage pipeline. The flag register writes the condition flags; this block reads them.
- Evaluates B.cond and CBZ branches sitting in the ID stage, using either the committed flags or the flags being produced in EX this cycle.
- Raises a registered taken pulse and a multi-cycle flush.
- Inserts a stall when flags are not yet usable.

Parameters:
FLUSH_SLOTS, 2, cycles flush stays asserted after a taken branch; legal range 1..7.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
id_valid  in  1  ID stage holds a valid instruction
id_bcond  in  1  ID instruction is B.cond
id_cbz  in  1  ID instruction is CBZ
id_cond  in  4  ARMv8 condition field of B.cond
id_reg_zero  in  1  CBZ source register read back as zero
ex_setflags  in  1  EX instruction is a flag-setting (S) instruction
ex_negative  in  1  ALU negative flag from EX
ex_zero  in  1  ALU zero flag from EX
ex_overflow  in  1  ALU overflow flag from EX
ex_carry_out  in  1  ALU carry-out flag from EX
negative_flag  in  1  committed N from the flag register
zero_flag  in  1  committed Z from the flag register
overflow_flag  in  1  committed V from the flag register
carry_out_flag  in  1  committed C from the flag register
id_stall  out  1  combinational; hold PC and IF/ID this cycle
br_taken  out  1  registered one-cycle pulse; branch resolved taken
flush  out  1  registered; squash younger instructions

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE, counter=0.
  - br_taken=0, flush=0, id_stall=0.
  - Reset in WAIT or FLUSH abandons the branch; no pulse follows.
- Branch request: req = id_valid & (id_bcond | id_cbz). If both type bits are high, B.cond wins.
- Condition decode (N,Z,V,C = selected flags):
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !(C&!Z); A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE !(!Z&(N==V)).
  - E and F: always taken.
- CBZ: taken = id_reg_zero. Never depends on the flags and never stalls.
- States: IDLE, WAIT, FLUSH. The WAIT state exists only without FLAG_FWD_EN.
- IDLE:
  - No req: stay in IDLE.
  - req resolvable this cycle: evaluate.
    - Taken: next cycle br_taken=1, flush=1, counter=FLUSH_SLOTS-1, state=FLUSH; if FLUSH_SLOTS=1, state=IDLE instead.
    - Not taken: stay in IDLE, all outputs 0.
- FLUSH:
  - flush=1 every cycle; br_taken=1 only in the first cycle.
  - Decrement the counter; go to IDLE when counter=0. Total flush width is exactly FLUSH_SLOTS cycles.
  - req is ignored, since the ID instruction is being squashed.
- Outputs depend only on state and counter (registered), except id_stall.
- Latency: branch present in ID at edge t gives br_taken high in cycle t+1 (t+2 when a stall is taken).

Optional Feature:
Macro FLAG_FWD_EN.
- Defined:
  - B.cond in IDLE with ex_setflags=1 uses the ex_* flags.
  - Otherwise it uses the committed flags.
  - id_stall is tied to 0 and WAIT is unreachable.
- Undefined:
  - B.cond in IDLE with ex_setflags=1: id_stall=1 that cycle, nothing is evaluated, and state goes to WAIT.
  - WAIT: evaluate from the committed flags, with id_stall=0 and ex_setflags ignored. Then go to FLUSH (taken) or IDLE (not taken).
  - B.cond with ex_setflags=0 resolves in IDLE from the committed flags.

Test Plan:
1. Reset held 2 cycles mid-FLUSH, then released -> br_taken=0, flush=0, id_stall=0 on the first cycle after release.
2. Committed Z=1, ex_setflags=0, B.cond id_cond=0 (EQ) -> br_taken pulse 1 cycle later; flush high exactly 2 cycles (FLUSH_SLOTS=2); a req arriving during FLUSH produces no second pulse.
3. Committed N=1 V=0, id_cond=A (GE) -> no br_taken, no flush. Then id_cond=B (LT) -> taken. Sweep all 16 conditions against all 16 NZVC combos, checked against a reference model.
4. CBZ with id_reg_zero=1 and ex_setflags=1 -> id_stall stays 0; taken 1 cycle later. With id_reg_zero=0 -> not taken.
5. ex_setflags=1 with ex_zero=1 while committed Z=0, B.cond EQ:
   - FLAG_FWD_EN defined -> id_stall=0, taken 1 cycle later.
   - Undefined -> id_stall=1 for one cycle; committed Z then set to 1; taken 2 cycles after the request.
6. FLUSH_SLOTS=1 build: taken branch -> flush high exactly 1 cycle; a back-to-back branch in the following cycle resolves normally.

Source files
------------

// File: rtl/cond_branch_if.sv
// cond_branch_if: ID/EX/flag-register view seen by the conditional branch unit.
// The pipeline side (master) drives branch and flag information and receives
// the stall, taken and flush indications back from the branch unit (slave).
interface cond_branch_if;
  logic       id_valid;
  logic       id_bcond;
  logic       id_cbz;
  logic [3:0] id_cond;
  logic       id_reg_zero;
  logic       ex_setflags;
  logic       ex_negative;
  logic       ex_zero;
  logic       ex_overflow;
  logic       ex_carry_out;
  logic       negative_flag;
  logic       zero_flag;
  logic       overflow_flag;
  logic       carry_out_flag;
  logic       id_stall;
  logic       br_taken;
  logic       flush;

  modport master (
    output id_valid, id_bcond, id_cbz, id_cond, id_reg_zero,
    output ex_setflags, ex_negative, ex_zero, ex_overflow, ex_carry_out,
    output negative_flag, zero_flag, overflow_flag, carry_out_flag,
    input  id_stall, br_taken, flush
  );

  modport slave (
    input  id_valid, id_bcond, id_cbz, id_cond, id_reg_zero,
    input  ex_setflags, ex_negative, ex_zero, ex_overflow, ex_carry_out,
    input  negative_flag, zero_flag, overflow_flag, carry_out_flag,
    output id_stall, br_taken, flush
  );
endinterface

// File: rtl/cond_branch_unit.sv
// cond_branch_unit: resolves B.cond / CBZ branches in ID, emitting a registered
// taken pulse and a FLUSH_SLOTS-cycle flush.
// Optional macro FLAG_FWD_EN: when defined, B.cond uses the flags being
// produced in EX instead of stalling for them (the WAIT state disappears).
module cond_branch_unit #(
  parameter int FLUSH_SLOTS = 2
) (
  input logic        clk,
  input logic        reset,
  cond_branch_if.slave bus
);

`ifdef FLAG_FWD_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    WAIT  = 2'd2
  } state_t;
`endif

  localparam logic [2:0] LAST_SLOT = 3'(FLUSH_SLOTS - 1);

  state_t     state, state_n;
  logic [2:0] counter, counter_n;
  logic       taken_q, taken_n;
  logic       flush_q, flush_n;
  logic       stall;
  logic       req;
  logic       go;
  logic       hit;
  logic       hit_committed;

  // ARMv8 condition evaluation for a given NZVC set.
  function automatic logic cond_eval(input logic [3:0] cond, input logic n,
                                     input logic z, input logic v, input logic c);
    logic r;
    case (cond)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = c;
      4'h3:    r = !c;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = c & !z;
      4'h9:    r = !(c & !z);
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z & (n == v);
      4'hD:    r = !(!z & (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign req = bus.id_valid & (bus.id_bcond | bus.id_cbz);
  assign hit_committed = cond_eval(bus.id_cond, bus.negative_flag, bus.zero_flag,
                                   bus.overflow_flag, bus.carry_out_flag);

`ifdef FLAG_FWD_EN
  logic hit_ex;
  assign hit_ex = cond_eval(bus.id_cond, bus.ex_negative, bus.ex_zero,
                            bus.ex_overflow, bus.ex_carry_out);
`else
  // EX flag values only matter when forwarding; here only ex_setflags is used.
  logic unused_ex_flags;
  assign unused_ex_flags = ^{bus.ex_negative, bus.ex_zero, bus.ex_overflow, bus.ex_carry_out};
`endif

  // Next-state, stall decision and next registered outputs.
  always_comb begin
    state_n   = state;
    counter_n = counter;
    taken_n   = 1'b0;
    flush_n   = 1'b0;
    stall     = 1'b0;
    go        = 1'b0;
    hit       = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (bus.id_bcond) begin
`ifdef FLAG_FWD_EN
            go  = 1'b1;
            hit = bus.ex_setflags ? hit_ex : hit_committed;
`else
            if (bus.ex_setflags) begin
              stall   = 1'b1;
              state_n = WAIT;
            end else begin
              go  = 1'b1;
              hit = hit_committed;
            end
`endif
          end else begin
            go  = 1'b1;
            hit = bus.id_reg_zero;
          end
        end
      end
`ifndef FLAG_FWD_EN
      WAIT: begin
        go  = 1'b1;
        hit = hit_committed;
      end
`endif
      FLUSH: begin
        if (counter == 3'd0) begin
          state_n = IDLE;
        end else begin
          counter_n = counter - 3'd1;
          flush_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (go) begin
      state_n = IDLE;
      if (hit) begin
        taken_n   = 1'b1;
        flush_n   = 1'b1;
        counter_n = LAST_SLOT;
        state_n   = (FLUSH_SLOTS == 1) ? IDLE : FLUSH;
      end
    end
  end

  // State, slot counter and registered outputs, synchronously reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      counter <= 3'd0;
      taken_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
      taken_q <= taken_n;
      flush_q <= flush_n;
    end
  end

  assign bus.id_stall = stall & ~reset;
  assign bus.br_taken = taken_q;
  assign bus.flush    = flush_q;

endmodule

// File: tb/tb_cond_branch_unit.sv
// tb_cond_branch_unit: scoreboard bench driving two branch units (FLUSH_SLOTS
// of 2 and 1) with identical stimulus and comparing against a reference model.
module tb_cond_branch_unit;

  localparam int SLOTS_A = 2;
  localparam int SLOTS_B = 1;

  typedef struct {
    int fl_left;
    bit pulse;
    bit waitp;
  } model_t;

  typedef struct {
    int dut;
    bit taken;
    bit flush;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [16:0] stim;

  bit       t_rst;
  bit       t_valid, t_bcond, t_cbz, t_rz, t_setf;
  bit [3:0] t_cond, t_exf, t_cf;

  int checks = 0;
  int errors = 0;
  model_t ma, mb;
  exp_t sb[$];

  cond_branch_if bus_a();
  cond_branch_if bus_b();

  cond_branch_unit #(.FLUSH_SLOTS(SLOTS_A)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  cond_branch_unit #(.FLUSH_SLOTS(SLOTS_B)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  assign {bus_a.id_valid, bus_a.id_bcond, bus_a.id_cbz, bus_a.id_cond, bus_a.id_reg_zero,
          bus_a.ex_setflags, bus_a.ex_negative, bus_a.ex_zero, bus_a.ex_overflow, bus_a.ex_carry_out,
          bus_a.negative_flag, bus_a.zero_flag, bus_a.overflow_flag, bus_a.carry_out_flag} = stim;
  assign {bus_b.id_valid, bus_b.id_bcond, bus_b.id_cbz, bus_b.id_cond, bus_b.id_reg_zero,
          bus_b.ex_setflags, bus_b.ex_negative, bus_b.ex_zero, bus_b.ex_overflow, bus_b.ex_carry_out,
          bus_b.negative_flag, bus_b.zero_flag, bus_b.overflow_flag, bus_b.carry_out_flag} = stim;

  always #5 clk = ~clk;

  // Hard time limit so the run cannot hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference condition check in the ARM base-condition-plus-invert form.
  function automatic bit refCond(input bit [3:0] cond, input bit [3:0] nzvc);
    bit n, z, v, c, base;
    n = nzvc[3]; z = nzvc[2]; v = nzvc[1]; c = nzvc[0];
    case (cond[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: base = 1'b1;
    endcase
    if (cond[0] && cond[3:1] != 3'd7) base = !base;
    return base;
  endfunction

  function automatic bit modelBusy(input model_t m, input int slots);
    return (m.fl_left > 0) && (slots > 1);
  endfunction

  function automatic bit modelStall(input model_t m, input int slots);
`ifdef FLAG_FWD_EN
    return 1'b0;
`else
    return !t_rst && !modelBusy(m, slots) && !m.waitp &&
           t_valid && t_bcond && t_setf;
`endif
  endfunction

  function automatic model_t nextModel(input model_t m, input int slots);
    model_t nm;
    bit fire;
    nm = m;
    fire = 1'b0;
    nm.pulse = 1'b0;
    if (t_rst) begin
      nm.fl_left = 0;
      nm.waitp = 1'b0;
    end else if (modelBusy(m, slots)) begin
      nm.fl_left = m.fl_left - 1;
    end else begin
      nm.fl_left = 0;
      if (m.waitp) begin
        nm.waitp = 1'b0;
        fire = refCond(t_cond, t_cf);
      end else if (t_valid && (t_bcond || t_cbz)) begin
        if (t_bcond) begin
`ifdef FLAG_FWD_EN
          fire = refCond(t_cond, t_setf ? t_exf : t_cf);
`else
          if (t_setf) nm.waitp = 1'b1;
          else fire = refCond(t_cond, t_cf);
`endif
        end else begin
          fire = t_rz;
        end
      end
      if (fire) begin
        nm.pulse = 1'b1;
        nm.fl_left = slots;
      end
    end
    return nm;
  endfunction

  task automatic applyStimulus(input bit r, input bit v, input bit bc, input bit cz,
                               input bit [3:0] cnd, input bit rz, input bit sf,
                               input bit [3:0] exf, input bit [3:0] cf);
    exp_t e;
    t_rst = r; t_valid = v; t_bcond = bc; t_cbz = cz; t_cond = cnd;
    t_rz = rz; t_setf = sf; t_exf = exf; t_cf = cf;
    reset = r;
    stim = {v, bc, cz, cnd, rz, sf, exf, cf};
    #1;
    checkOutput("stall_a", bus_a.id_stall, modelStall(ma, SLOTS_A));
    checkOutput("stall_b", bus_b.id_stall, modelStall(mb, SLOTS_B));
    ma = nextModel(ma, SLOTS_A);
    mb = nextModel(mb, SLOTS_B);
    sb.push_back('{0, ma.pulse, ma.fl_left > 0});
    sb.push_back('{1, mb.pulse, mb.fl_left > 0});
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.dut == 0) begin
        checkOutput("taken_a", bus_a.br_taken, e.taken);
        checkOutput("flush_a", bus_a.flush, e.flush);
      end else begin
        checkOutput("taken_b", bus_b.br_taken, e.taken);
        checkOutput("flush_b", bus_b.flush, e.flush);
      end
    end
  endtask

  task automatic idleCycles(input int n, input bit [3:0] cf);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 4'h0, cf);
  endtask

  task automatic bcondReq(input bit [3:0] cnd, input bit sf, input bit [3:0] exf, input bit [3:0] cf);
    applyStimulus(0, 1, 1, 0, cnd, 0, sf, exf, cf);
  endtask

  initial begin
    ma = '{0, 1'b0, 1'b0};
    mb = '{0, 1'b0, 1'b0};
    @(negedge clk);
    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
    applyStimulus(1, 0, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
    idleCycles(1, 4'h0);

    $display("[TB] EQ taken, req during flush, back-to-back");
    bcondReq(4'h0, 0, 4'h0, 4'b0100);
    bcondReq(4'h0, 0, 4'h0, 4'b0100);
    idleCycles(3, 4'b0100);

    $display("[TB] GE not taken, LT taken");
    bcondReq(4'hA, 0, 4'h0, 4'b1000);
    idleCycles(1, 4'b1000);
    bcondReq(4'hB, 0, 4'h0, 4'b1000);
    idleCycles(2, 4'b1000);

    $display("[TB] condition sweep");
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        bcondReq(4'(c), 0, 4'h0, 4'(f));
        idleCycles(2, 4'(f));
      end
    end

    $display("[TB] CBZ");
    applyStimulus(0, 1, 0, 1, 4'h0, 1, 1, 4'hF, 4'h0);
    idleCycles(2, 4'h0);
    applyStimulus(0, 1, 0, 1, 4'h0, 0, 1, 4'hF, 4'h0);
    idleCycles(1, 4'h0);
    applyStimulus(0, 1, 1, 1, 4'h0, 1, 0, 4'h0, 4'h0);
    idleCycles(1, 4'h0);

    $display("[TB] flags produced in EX");
    bcondReq(4'h0, 1, 4'b0100, 4'b0000);
`ifdef FLAG_FWD_EN
    idleCycles(1, 4'b0100);
`else
    bcondReq(4'h0, 0, 4'h0, 4'b0100);
`endif
    idleCycles(2, 4'b0100);

    $display("[TB] reset mid-flush and mid-wait");
    bcondReq(4'hE, 0, 4'h0, 4'h0);
    applyStimulus(1, 1, 1, 0, 4'hE, 0, 0, 4'h0, 4'h0);
    applyStimulus(1, 1, 1, 0, 4'hE, 0, 0, 4'h0, 4'h0);
    idleCycles(2, 4'h0);
    bcondReq(4'hE, 1, 4'h0, 4'h0);
    applyStimulus(1, 1, 1, 0, 4'hE, 0, 0, 4'h0, 4'h0);
    idleCycles(2, 4'h0);

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                    1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                    1'($urandom), 4'($urandom), 4'($urandom));
    end
    idleCycles(3, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
